// File: rtl/cont_bounce_monitor_pkg.sv
// cont_mon_pkg: shared types and default constants for the bounce-counter
// monitor.
//   mon_state_t : tracking state of the monitor.
//   CONT_W      : default width of the monitored count.
//   CONT_MAX    : default top value of the triangle sequence (2**CONT_W-1).
package cont_mon_pkg;

  typedef enum logic [2:0] {
    SYNC      = 3'd0,
    UP        = 3'd1,
    DOWN      = 3'd2,
    TOP_DWELL = 3'd3,
    BOT_DWELL = 3'd4
  } mon_state_t;

  localparam int CONT_W   = 4;
  localparam int CONT_MAX = 15;

endpackage

// File: rtl/cont_bounce_monitor_sat_counter.sv
// sat_counter: counter that counts up by one per inc and sticks at all-ones.
// It never wraps.
//   clk : rising-edge clock
//   rst : synchronous active-low reset, clears q
//   inc : count request for this edge
//   q   : current count, saturating at 2**W-1
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] FULL_V = {W{1'b1}};
  localparam logic [W-1:0] ONE_V  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO_V = {W{1'b0}};

  // Count register: increments only below the saturation value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= ZERO_V;
    end else if (inc && (q != FULL_V)) begin
      q <= q + ONE_V;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/cont_bounce_monitor.sv
// cont_bounce_monitor: locks onto the 0..MAX..0 triangle sequence of an
// up/down bounce counter and reports mismatches, peaks, troughs and periods.
//   clk        : rising-edge clock
//   rst        : synchronous active-low reset
//   en         : sample-valid, cont_in is evaluated only when en=1
//   cont_in    : observed counter value
//   locked     : monitor is tracking a valid sequence
//   dir        : direction of the next expected step (0 up, 1 down)
//   peak       : 1-cycle strobe, MAX accepted while ascending
//   trough     : 1-cycle strobe, 0 accepted while descending
//   err        : 1-cycle strobe on a mismatch
//   err_cnt    : saturating mismatch count
//   period_cnt : saturating count of completed periods
// All outputs are registered and reflect the previous sample taken with en=1.
module cont_bounce_monitor
  import cont_mon_pkg::*;
#(
  parameter int WIDTH = CONT_W,
  parameter int MAX   = CONT_MAX,
  parameter int DWELL = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] cont_in,
  output logic             locked,
  output logic             dir,
  output logic             peak,
  output logic             trough,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] period_cnt
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam bit               DWELL_EN = (DWELL != 0);

  mon_state_t       state_r, state_s;
  mon_state_t       eff_state_s;
  logic [WIDTH-1:0] exp_r, exp_s;
  logic [WIDTH-1:0] prev_r, prev_s;
  logic             have_prev_r, have_prev_s;
  logic             accept_s;
  logic             locking_s;
  logic             peak_s, trough_s, err_s, per_inc_s;
  logic             locked_r, dir_r, peak_r, trough_r, err_r;

  // Next-state, expected-value and strobe decode for one sample.
  always_comb begin
    state_s     = state_r;
    exp_s       = exp_r;
    prev_s      = prev_r;
    have_prev_s = have_prev_r;
    eff_state_s = state_r;
    accept_s    = 1'b0;
    locking_s   = 1'b0;
    peak_s      = 1'b0;
    trough_s    = 1'b0;
    err_s       = 1'b0;
    per_inc_s   = 1'b0;
    if (en) begin
      if (state_r == SYNC) begin
        prev_s      = cont_in;
        have_prev_s = 1'b1;
        // Step tests are guarded by the bounds so 15->0 / 0->15 never count.
        if (have_prev_r && (prev_r != MAX_V) && (cont_in == prev_r + ONE_V)) begin
          eff_state_s = UP;
          accept_s    = 1'b1;
          locking_s   = 1'b1;
        end else if (have_prev_r && (prev_r != ZERO_V) && (cont_in == prev_r - ONE_V)) begin
          eff_state_s = DOWN;
          accept_s    = 1'b1;
          locking_s   = 1'b1;
        end else begin
          eff_state_s = SYNC;
        end
      end else if (cont_in == exp_r) begin
        accept_s = 1'b1;
      end else begin
        err_s       = 1'b1;
        state_s     = SYNC;
        prev_s      = cont_in;
        have_prev_s = 1'b1;
      end

      // Accepted sample: the locking sample reuses the same rules but
      // suppresses the strobes and the period count.
      if (accept_s) begin
        case (eff_state_s)
          UP: begin
            if (cont_in == MAX_V) begin
              peak_s = !locking_s;
              if (DWELL_EN) begin
                state_s = TOP_DWELL;
                exp_s   = MAX_V;
              end else begin
                state_s = DOWN;
                exp_s   = MAX_V - ONE_V;
              end
            end else begin
              state_s = UP;
              exp_s   = cont_in + ONE_V;
            end
          end
          TOP_DWELL: begin
            state_s = DOWN;
            exp_s   = MAX_V - ONE_V;
          end
          DOWN: begin
            if (cont_in == ZERO_V) begin
              trough_s  = !locking_s;
              per_inc_s = !locking_s;
              if (DWELL_EN) begin
                state_s = BOT_DWELL;
                exp_s   = ZERO_V;
              end else begin
                state_s = UP;
                exp_s   = ONE_V;
              end
            end else begin
              state_s = DOWN;
              exp_s   = cont_in - ONE_V;
            end
          end
          BOT_DWELL: begin
            state_s = UP;
            exp_s   = ONE_V;
          end
          default: begin
            state_s = SYNC;
          end
        endcase
      end else begin
        locking_s = 1'b0;
      end
    end else begin
      state_s = state_r;
    end
  end

  // State and output registers; en=0 holds state and clears the strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= SYNC;
      exp_r       <= ZERO_V;
      prev_r      <= ZERO_V;
      have_prev_r <= 1'b0;
      locked_r    <= 1'b0;
      dir_r       <= 1'b0;
      peak_r      <= 1'b0;
      trough_r    <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      exp_r       <= exp_s;
      prev_r      <= prev_s;
      have_prev_r <= have_prev_s;
      locked_r    <= (state_s != SYNC);
      dir_r       <= (state_s == DOWN) || (state_s == TOP_DWELL);
      peak_r      <= peak_s;
      trough_r    <= trough_s;
      err_r       <= err_s;
    end
  end

  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_s),
    .q   (err_cnt)
  );

  sat_counter #(.W(CNT_W)) u_period_cnt (
    .clk (clk),
    .rst (rst),
    .inc (per_inc_s),
    .q   (period_cnt)
  );

  assign locked = locked_r;
  assign dir    = dir_r;
  assign peak   = peak_r;
  assign trough = trough_r;
  assign err    = err_r;

endmodule

// File: tb/tb_cont_bounce_monitor.sv
// tb_cont_bounce_monitor: two monitors (DWELL=0 and DWELL=1) share one
// stimulus; expected outputs are queued per sample and compared one edge later.
module tb_cont_bounce_monitor;

  typedef struct packed {
    logic       locked;
    logic       dir;
    logic       peak;
    logic       trough;
    logic       err;
    logic [7:0] err_cnt;
    logic [7:0] period_cnt;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] cont_in;

  logic       locked0, dir0, peak0, trough0, err0;
  logic [7:0] err_cnt0, period_cnt0;
  logic       locked1, dir1, peak1, trough1, err1;
  logic [7:0] err_cnt1, period_cnt1;

  obs_t obs0, obs1;
  obs_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  cont_bounce_monitor #(.WIDTH(4), .MAX(15), .DWELL(0), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .en(en), .cont_in(cont_in),
    .locked(locked0), .dir(dir0), .peak(peak0), .trough(trough0), .err(err0),
    .err_cnt(err_cnt0), .period_cnt(period_cnt0)
  );

  cont_bounce_monitor #(.WIDTH(4), .MAX(15), .DWELL(1), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .en(en), .cont_in(cont_in),
    .locked(locked1), .dir(dir1), .peak(peak1), .trough(trough1), .err(err1),
    .err_cnt(err_cnt1), .period_cnt(period_cnt1)
  );

  assign obs0 = {locked0, dir0, peak0, trough0, err0, err_cnt0, period_cnt0};
  assign obs1 = {locked1, dir1, peak1, trough1, err1, err_cnt1, period_cnt1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input bit l, input bit d, input bit p, input bit t,
                              input bit e, input int ec, input int pc);
    mk = {l, d, p, t, e, 8'(ec), 8'(pc)};
  endfunction

  task automatic step(input logic [3:0] v, input logic e);
    cont_in = v;
    en      = e;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    en      = 1'b1;
    cont_in = 4'd0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    obs_t e;
    do_reset();
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    e = sb_q.pop_front();
    checks++;
    if (obs0 !== e) begin
      errors++;
      $display("FAIL reset_dwell0 got %h want %h", obs0, e);
    end
    e = sb_q.pop_front();
    checks++;
    if (obs1 !== e) begin
      errors++;
      $display("FAIL reset_dwell1 got %h want %h", obs1, e);
    end
  endtask

  task automatic test_stream_dwell0();
    obs_t e;
    do_reset();
    for (int i = 0; i < 95; i++) begin
      int p = i % 30;
      int v = (p <= 15) ? p : 30 - p;
      sb_q.push_back(mk(i > 0, p >= 15, p == 15, (p == 0) && (i > 0), 0, 0, i / 30));
      step(4'(v), 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        errors++;
        $display("FAIL stream_dwell0 sample %0d got %h want %h", i, obs0, e);
      end
    end
  endtask

  task automatic test_stream_dwell1();
    obs_t e;
    do_reset();
    for (int i = 0; i < 97; i++) begin
      int p = i % 32;
      int v = (p <= 15) ? p : ((p == 16) ? 15 : 31 - p);
      sb_q.push_back(mk(i > 0, (p >= 15) && (p <= 30), p == 15, p == 31, 0, 0, (i + 1) / 32));
      step(4'(v), 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (obs1 !== e) begin
        errors++;
        $display("FAIL stream_dwell1 sample %0d got %h want %h", i, obs1, e);
      end
      // A repeated 15 is a mismatch for the no-dwell flavour.
      if (i == 16) begin
        checks++;
        if (err0 !== 1'b1) begin
          errors++;
          $display("FAIL dwell_stream_on_dwell0 err got %b want 1", err0);
        end
      end
    end
  endtask

  task automatic test_mismatch_relock();
    logic [3:0] vals [7] = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd10, 4'd11};
    bit         lck  [7] = '{0, 1, 1, 1, 0, 1, 1};
    bit         erb  [7] = '{0, 0, 0, 0, 1, 0, 0};
    int         ecn  [7] = '{0, 0, 0, 0, 1, 1, 1};
    obs_t e;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      sb_q.push_back(mk(lck[i], 0, 0, 0, erb[i], ecn[i], 0));
      step(vals[i], 1'b1);
      e = sb_q.pop_front();
      checks++;
      if (obs0 !== e) begin
        errors++;
        $display("FAIL mismatch_relock sample %0d got %h want %h", i, obs0, e);
      end
    end
  endtask

  task automatic test_en_hold();
    obs_t e;
    // Hold immediately after a peak: peak must drop while state holds.
    do_reset();
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); step(4'd13, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL en_hold_peak s13 got %h want %h", obs0, e); end
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); step(4'd14, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL en_hold_peak s14 got %h want %h", obs0, e); end
    sb_q.push_back(mk(1, 1, 1, 0, 0, 0, 0)); step(4'd15, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL en_hold_peak s15 got %h want %h", obs0, e); end
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0)); step(4'd3, 1'b0);
      e = sb_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL en_hold_peak idle %0d got %h want %h", i, obs0, e); end
    end
    sb_q.push_back(mk(1, 1, 0, 0, 0, 0, 0)); step(4'd14, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL en_hold_peak resume got %h want %h", obs0, e); end

    // Locked ascending at 7, five idle cycles with a wrong value on the bus.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk(i > 0, 0, 0, 0, 0, 0, 0));
      step(4'(4 + i), 1'b1);
      e = sb_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL en_hold_lock sample %0d got %h want %h", i, obs0, e); end
    end
    for (int i = 0; i < 5; i++) begin
      sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      step(4'd3, 1'b0);
      e = sb_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL en_hold_idle cycle %0d got %h want %h", i, obs0, e); end
    end
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); step(4'd8, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL en_hold_resume got %h want %h", obs0, e); end
  endtask

  task automatic test_no_lock_alternating();
    obs_t e;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
      step((i % 2 == 0) ? 4'd0 : 4'd15, 1'b1);
      e = sb_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL alt_0_15 sample %0d got %h want %h", i, obs0, e); end
    end
  endtask

  task automatic test_err_saturation();
    obs_t e;
    do_reset();
    // Pattern 2,3,8,9,...: each pair relocks and the next jump is a mismatch.
    for (int i = 0; i < 600; i++) begin
      int v  = ((i % 4) < 2) ? 2 + (i % 2) : 8 + (i % 2);
      int n  = (i >= 2) ? i / 2 : 0;
      int ec = (n > 255) ? 255 : n;
      sb_q.push_back(mk(i % 2 == 1, 0, 0, 0, (i % 2 == 0) && (i >= 2), ec, 0));
      step(4'(v), 1'b1);
      e = sb_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL err_saturation sample %0d got %h want %h", i, obs0, e); end
    end
  endtask

  task automatic test_reset_mid();
    obs_t e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(mk(i > 0, i > 0, 0, 0, 0, 0, 0));
      step(4'(12 - i), 1'b1);
      e = sb_q.pop_front(); checks++;
      if (obs0 !== e) begin errors++; $display("FAIL reset_mid lock sample %0d got %h want %h", i, obs0, e); end
    end
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    do_reset();
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_mid after_reset got %h want %h", obs0, e); end
    sb_q.push_back(mk(0, 0, 0, 0, 0, 0, 0)); step(4'd4, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_mid first_sample got %h want %h", obs0, e); end
    sb_q.push_back(mk(1, 0, 0, 0, 0, 0, 0)); step(4'd5, 1'b1);
    e = sb_q.pop_front(); checks++;
    if (obs0 !== e) begin errors++; $display("FAIL reset_mid relock got %h want %h", obs0, e); end
  endtask

  initial begin
    rst     = 1'b0;
    en      = 1'b0;
    cont_in = 4'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_stream_dwell0();
    test_stream_dwell1();
    test_mismatch_relock();
    test_en_hold();
    test_no_lock_alternating();
    test_err_saturation();
    test_reset_mid();
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d want 0", sb_q.size());
    end
    checks++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
